// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   - FSM state encodings (IDLE/RUN/DONE) as plain localparams and as an enum
//     built from them, so other blocks can decode the raw 2-bit value if needed.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Half-subtractor cell: d = x - y (one bit), bo = borrow out.
// Ports:
//   x   in   minuend bit
//   y   in   subtrahend bit
//   d   out  difference bit
//   bo  out  borrow out
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per
// clock, LSB first, with a registered borrow between bit steps.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request, only honoured in IDLE
//   a       in   minuend, captured when start is accepted
//   b       in   subtrahend, captured when start is accepted
//   busy    out  high while the bit loop runs
//   done    out  one-cycle pulse, diff/borrow valid
//   diff    out  registered difference, held until the next completion
//   borrow  out  registered final borrow (a < b)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit subtracted per clock, WIDTH cycles
// DONE  | results just updated, done pulse
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Only WIDTH-1 bits of partial result are kept: the last bit goes
    // straight from the cell into diff on the final step.
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             d1, bo1, d_bit, bo2, bout;
    logic [WIDTH-1:0] res_next;

    // Full-subtract cell from two half subtractors: (x - y) - bin.
    half_subtractor u_hs_xy (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .d  (d1),
        .bo (bo1)
    );

    half_subtractor u_hs_bin (
        .x  (d1),
        .y  (bin_q),
        .d  (d_bit),
        .bo (bo2)
    );

    assign bout     = bo1 | bo2;
    assign res_next = {d_bit, res_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_next[WIDTH-1:1];
                bin_d = bout;
                if (cnt_q == CNT_LAST) begin
                    diff_d   = res_next;
                    borrow_d = bout;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st8, st13;
    logic [7:0]  a8, b8;
    logic [12:0] a13, b13;
    logic        busy8, done8, borrow8;
    logic [7:0]  diff8;
    logic        busy13, done13, borrow13;
    logic [12:0] diff13;

    int errs = 0;
    int checks = 0;

    logic [8:0]  q8[$];
    logic [13:0] q13[$];
    logic [8:0]  last8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    serial_subtractor #(.WIDTH(13)) dut13 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st13),
        .a      (a13),
        .b      (b13),
        .busy   (busy13),
        .done   (done13),
        .diff   (diff13),
        .borrow (borrow13)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected {borrow,diff}.
    always @(negedge clk) begin : mon
        logic [8:0]  e8;
        logic [13:0] e13;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_done8: got done with diff=0x%0h borrow=%0b required no done",
                         diff8, borrow8);
            end else begin
                e8 = q8.pop_front();
                chk("result8", {23'd0, borrow8, diff8}, {23'd0, e8});
            end
        end
        if (done13 === 1'b1) begin
            if (q13.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_done13: got done with diff=0x%0h borrow=%0b required no done",
                         diff13, borrow13);
            end else begin
                e13 = q13.pop_front();
                chk("result13", {18'd0, borrow13, diff13}, {18'd0, e13});
            end
        end
    end

    // One operation: start for one edge, count edges to done, check pulse shape.
    // inj_at > 0 re-asserts start with other operands while the DUT is in RUN.
    task automatic run_op(input bit w13, input logic [12:0] av, input logic [12:0] bv,
                          input int inj_at);
        int   k;
        int   wd;
        logic dn;
        logic [7:0] a_lo, b_lo;
        a_lo = av[7:0];
        b_lo = bv[7:0];
        wd = w13 ? 13 : 8;
        if (w13) begin
            a13 = av; b13 = bv; st13 = 1'b1;
            q13.push_back({(av < bv), 13'(av - bv)});
        end else begin
            a8 = a_lo; b8 = b_lo; st8 = 1'b1;
            q8.push_back({(a_lo < b_lo), 8'(a_lo - b_lo)});
        end
        @(posedge clk); #1;
        st8 = 1'b0; st13 = 1'b0;
        a8 = ~a8; b8 = ~b8; a13 = ~a13; b13 = ~b13;
        k = 0;
        dn = 1'b0;
        while (!dn && k < 40) begin
            if (!w13 && k == 1)
                chk("hold_during_run", {23'd0, borrow8, diff8}, {23'd0, last8});
            if (inj_at != 0 && k == inj_at) begin
                if (w13) begin a13 = 13'h1234; b13 = 13'h0042; st13 = 1'b1; end
                else     begin a8  = 8'd1;     b8  = 8'd200;    st8  = 1'b1; end
            end
            @(posedge clk); #1;
            st8 = 1'b0; st13 = 1'b0;
            k++;
            dn = w13 ? done13 : done8;
        end
        chk(w13 ? "latency13" : "latency8", k, wd);
        chk("busy_in_done", {31'd0, (w13 ? busy13 : busy8)}, 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, (w13 ? done13 : done8)}, 32'd0);
        chk("busy_after_done", {31'd0, (w13 ? busy13 : busy8)}, 32'd0);
        if (!w13) last8 = {(a_lo < b_lo), 8'(a_lo - b_lo)};
    endtask

    initial begin
        logic [12:0] ra, rb;

        tbl[0] = '{a: 8'd200,  b: 8'd55,   d: 8'd145,  bo: 1'b0};
        tbl[1] = '{a: 8'd5,    b: 8'd10,   d: 8'hFB,   bo: 1'b1};
        tbl[2] = '{a: 8'h5A,   b: 8'h5A,   d: 8'h00,   bo: 1'b0};
        tbl[3] = '{a: 8'h00,   b: 8'hFF,   d: 8'h01,   bo: 1'b1};
        tbl[4] = '{a: 8'hFF,   b: 8'h00,   d: 8'hFF,   bo: 1'b0};

        rst_n = 1'b0;
        st8 = 1'b0; st13 = 1'b0;
        a8 = '0; b8 = '0; a13 = '0; b13 = '0;
        last8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy8",   {31'd0, busy8},   32'd0);
        chk("rst_done8",   {31'd0, done8},   32'd0);
        chk("rst_diff8",   {24'd0, diff8},   32'd0);
        chk("rst_borrow8", {31'd0, borrow8}, 32'd0);
        chk("rst_busy13",  {31'd0, busy13},  32'd0);
        chk("rst_diff13",  {19'd0, diff13},  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: the queue holds the hand-computed expectations.
        for (int i = 0; i < 5; i++) begin
            a8 = tbl[i].a; b8 = tbl[i].b; st8 = 1'b1;
            q8.push_back({tbl[i].bo, tbl[i].d});
            @(posedge clk); #1;
            st8 = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            chk("tbl_done", {31'd0, done8}, 32'd1);
            @(posedge clk); #1;
            chk("tbl_done_low", {31'd0, done8}, 32'd0);
            last8 = {tbl[i].bo, tbl[i].d};
        end

        // Start re-asserted during RUN must be ignored; next op normal.
        run_op(1'b0, 13'd100, 13'd30, 2);
        run_op(1'b0, 13'd1, 13'd200, 0);

        // Reset in the middle of RUN (diff currently nonzero).
        a8 = 8'd77; b8 = 8'd9; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy",   {31'd0, busy8},   32'd0);
        chk("midrst_done",   {31'd0, done8},   32'd0);
        chk("midrst_diff",   {24'd0, diff8},   32'd0);
        chk("midrst_borrow", {31'd0, borrow8}, 32'd0);
        rst_n = 1'b1;
        last8 = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_rst", {31'd0, busy8}, 32'd0);

        run_op(1'b0, 13'd42, 13'd43, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 13'($urandom_range(0, 255));
            rb = ($urandom_range(0, 9) == 0) ? ra : 13'($urandom_range(0, 255));
            run_op(1'b0, ra, rb, 0);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 13'($urandom_range(0, 8191));
            rb = ($urandom_range(0, 9) == 0) ? ra : 13'($urandom_range(0, 8191));
            run_op(1'b1, ra, rb, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q8_drained",  q8.size(),  32'd0);
        chk("q13_drained", q13.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
